// File: rtl/scroll_ctrl.sv
// Sequences message nibbles from the BRAM read port into a shifting display word.
// A step costs RD_LAT+1 cycles plus max(rate,1) RUN cycles; no backpressure, stop overrides all.
module scroll_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DIGITS = 8,
  parameter int RATE_W = 27,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic                pause,
  input  logic [ADDR_W-1:0]   msg_len,
  input  logic [RATE_W-1:0]   rate,
  input  logic [3:0]          rd_data,
  output logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_en,
  output logic [4*DIGITS-1:0] disp,
  output logic                busy,
  output logic                step,
  output logic                wrap
);
  localparam int PW = $clog2(DIGITS + 1);
  localparam logic [PW-1:0] PF_LAST = PW'(DIGITS - 1);
  // Unused when RD_LAT=1 because WAIT is never entered.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SHIFT, S_RUN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   len_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [ADDR_W-1:0]   rd_addr_d;
  logic [RATE_W-1:0]   rate_q;
  logic [RATE_W-1:0]   timer_q;
  logic [PW-1:0]       pcnt_q;
  logic                prefill_q;
  logic [1:0]          wcnt_q;
  logic [4*DIGITS-1:0] disp_q;
  logic                rd_en_q;
  logic                busy_q;
  logic                step_q;
  logic                wrap_q;
  logic                last_addr;
  logic                timer_done;

  assign last_addr  = (rd_addr_q == len_q - ADDR_W'(1));
  assign rd_addr_d  = last_addr ? '0 : rd_addr_q + ADDR_W'(1);
  assign timer_done = (timer_q == rate_q - RATE_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      rd_addr_q <= '0;
      rate_q    <= '0;
      timer_q   <= '0;
      pcnt_q    <= '0;
      prefill_q <= 1'b0;
      wcnt_q    <= '0;
      disp_q    <= '0;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      step_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      if (stop) begin
        // disp, rd_addr and the latched length/rate are deliberately kept
        state_q   <= S_IDLE;
        busy_q    <= 1'b0;
        timer_q   <= '0;
        pcnt_q    <= '0;
        prefill_q <= 1'b0;
        wcnt_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && (msg_len != '0)) begin
              len_q     <= msg_len;
              rate_q    <= (rate == '0) ? RATE_W'(1) : rate;
              rd_addr_q <= '0;
              timer_q   <= '0;
              pcnt_q    <= '0;
              prefill_q <= 1'b1;
              rd_en_q   <= 1'b1;
              busy_q    <= 1'b1;
              state_q   <= S_FETCH;
            end
          end
          S_FETCH: begin
            wcnt_q <= '0;
            if (RD_LAT > 1) state_q <= S_WAIT;
            else            state_q <= S_SHIFT;
          end
          S_WAIT: begin
            if (wcnt_q == WAIT_LAST) state_q <= S_SHIFT;
            else                     wcnt_q  <= wcnt_q + 2'd1;
          end
          S_SHIFT: begin
            disp_q    <= {disp_q[4*DIGITS-5:0], rd_data};
            step_q    <= 1'b1;
            wrap_q    <= last_addr;
            rd_addr_q <= rd_addr_d;
            if (prefill_q) begin
              pcnt_q <= pcnt_q + PW'(1);
              if (pcnt_q == PF_LAST) begin
                prefill_q <= 1'b0;
                state_q   <= S_RUN;
              end else begin
                rd_en_q <= 1'b1;
                state_q <= S_FETCH;
              end
            end else begin
              state_q <= S_RUN;
            end
          end
          S_RUN: begin
            if (!pause) begin
              if (timer_done) begin
                timer_q <= '0;
                rd_en_q <= 1'b1;
                state_q <= S_FETCH;
              end else begin
                timer_q <= timer_q + RATE_W'(1);
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // A fetch pulse is suppressed in the same cycle stop is seen.
  assign rd_en   = rd_en_q & ~stop;
  assign rd_addr = rd_addr_q;
  assign disp    = disp_q;
  assign busy    = busy_q;
  assign step    = step_q;
  assign wrap    = wrap_q;

endmodule
